// File: rtl/register_file_mp_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
package register_file_mp_pkg;
    localparam int N_REG_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(N_REG_DEF);
    localparam int ZERO_REG   = 0;
endpackage

// File: rtl/register_file_mp_if.sv
// Decode-stage register file bus: read ports, two write ports and the multiply reservation.
interface register_file_mp_if
    import register_file_mp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_RD   = 2
);
    logic [N_RD*ADDR_W-1:0] raddr;
    logic [N_RD*DATA_W-1:0] rdata;
    logic [N_RD-1:0]        rbusy;
    logic                   wen0;
    logic [ADDR_W-1:0]      waddr0;
    logic [DATA_W-1:0]      wdata0;
    logic                   wen1;
    logic [ADDR_W-1:0]      waddr1;
    logic [DATA_W-1:0]      wdata1;
    logic                   rsv_en;
    logic [ADDR_W-1:0]      rsv_addr;

    modport master (
        output raddr, wen0, waddr0, wdata0, wen1, waddr1, wdata1, rsv_en, rsv_addr,
        input  rdata, rbusy
    );
    modport slave (
        input  raddr, wen0, waddr0, wdata0, wen1, waddr1, wdata1, rsv_en, rsv_addr,
        output rdata, rbusy
    );
endinterface

// File: rtl/register_file_mp_reg_scoreboard.sv
// Per-register busy bits tracking destinations of in-flight multiplies.
module reg_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int N_REG  = N_REG_DEF,
    parameter int ADDR_W = $clog2(N_REG)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              wen1_i,
    input  logic [ADDR_W-1:0] waddr1_i,
    output logic [N_REG-1:0]  busy_o
);
    logic [N_REG-1:0] busy_q;
    logic [N_REG-1:0] busy_d;

    // Reservation is applied after the clear so a re-issued multiply keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < N_REG; i++) begin
            if (wen1_i && (waddr1_i == ADDR_W'(i)))
                busy_d[i] = 1'b0;
            if (rsv_en_i && (rsv_addr_i == ADDR_W'(i)))
                busy_d[i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports with port-0 priority, bypassed reads, busy scoreboard.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_REG  = N_REG_DEF,
    parameter int ADDR_W = $clog2(N_REG),
    parameter int N_RD   = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    register_file_mp_if.slave bus
);
    logic [DATA_W-1:0] regs_q [N_REG];
    logic [DATA_W-1:0] regs_d [N_REG];
    logic [N_REG-1:0]  busy;

    // Port 0 is applied last: it carries the younger instruction on a collision.
    always_comb begin
        regs_d = regs_q;
        if (bus.wen1 && (bus.waddr1 != ADDR_W'(ZERO_REG)))
            regs_d[bus.waddr1] = bus.wdata1;
        if (bus.wen0 && (bus.waddr0 != ADDR_W'(ZERO_REG)))
            regs_d[bus.waddr0] = bus.wdata0;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < N_REG; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(
        .N_REG  (N_REG),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .arst_n     (arst_n),
        .rsv_en_i   (bus.rsv_en),
        .rsv_addr_i (bus.rsv_addr),
        .wen1_i     (bus.wen1),
        .waddr1_i   (bus.waddr1),
        .busy_o     (busy)
    );

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            if (ra == ADDR_W'(ZERO_REG))
                rd = '0;
            else if (bus.wen0 && (bus.waddr0 == ra))
                rd = bus.wdata0;
            else if (bus.wen1 && (bus.waddr1 == ra))
                rd = bus.wdata1;
            else
                rd = regs_q[ra];
        end

        assign bus.rdata[k*DATA_W +: DATA_W] = rd;
        // A same-cycle multiply writeback clears busy early because its data is bypassed.
        assign bus.rbusy[k] = busy[ra] & ~(bus.wen1 && (bus.waddr1 == ra));
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Randomized and directed checks of register_file_mp against a behavioural array model.
module tb_register_file_mp;
    localparam int DATA_W = 32;
    localparam int N_REG  = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [DATA_W-1:0] mdl_reg  [N_REG];
    bit                mdl_busy [N_REG];

    register_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD)) bus_if ();

    register_file_mp #(
        .DATA_W (DATA_W),
        .N_REG  (N_REG),
        .ADDR_W (ADDR_W),
        .N_RD   (N_RD)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_REG; i++) begin
            mdl_reg[i]  = '0;
            mdl_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge, in program order: multiply WB, then pipeline WB.
    task automatic model_edge();
        if (!arst_n) begin
            model_clear();
        end else begin
            if (bus_if.wen1) begin
                if (bus_if.waddr1 != 0) mdl_reg[bus_if.waddr1] = bus_if.wdata1;
                mdl_busy[bus_if.waddr1] = 1'b0;
            end
            if (bus_if.wen0 && bus_if.waddr0 != 0) mdl_reg[bus_if.waddr0] = bus_if.wdata0;
            if (bus_if.rsv_en && bus_if.rsv_addr != 0) mdl_busy[bus_if.rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_ports();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] ed;
        bit                eb;
        for (int k = 0; k < N_RD; k++) begin
            a = bus_if.raddr[k*ADDR_W +: ADDR_W];
            if (a == 0)                                 ed = '0;
            else if (bus_if.wen0 && bus_if.waddr0 == a) ed = bus_if.wdata0;
            else if (bus_if.wen1 && bus_if.waddr1 == a) ed = bus_if.wdata1;
            else                                        ed = mdl_reg[a];
            eb = mdl_busy[a] && !(bus_if.wen1 && bus_if.waddr1 == a);
            chk($sformatf("rdata%0d[r%0d]", k, a), 64'(bus_if.rdata[k*DATA_W +: DATA_W]), 64'(ed));
            chk($sformatf("rbusy%0d[r%0d]", k, a), 64'(bus_if.rbusy[k]), 64'(eb));
        end
    endtask

    task automatic idle();
        bus_if.wen0 = 1'b0; bus_if.waddr0 = '0; bus_if.wdata0 = '0;
        bus_if.wen1 = 1'b0; bus_if.waddr1 = '0; bus_if.wdata1 = '0;
        bus_if.rsv_en = 1'b0; bus_if.rsv_addr = '0;
    endtask

    task automatic set_all_raddr(input logic [ADDR_W-1:0] a);
        for (int k = 0; k < N_RD; k++) bus_if.raddr[k*ADDR_W +: ADDR_W] = a;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        #4;
        check_ports();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        idle();
        set_all_raddr(5'd0);
        model_clear();
        arst_n = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < N_RD; k++) bus_if.raddr[k*ADDR_W +: ADDR_W] = ADDR_W'(k * 3 + 1);
        step();
        arst_n = 1'b1;

        // Register 0: writes through each port and a reservation are all dropped.
        set_all_raddr(5'd0);
        bus_if.wen0 = 1'b1; bus_if.waddr0 = 5'd0; bus_if.wdata0 = 32'hBEEF;
        step();
        idle();
        bus_if.wen1 = 1'b1; bus_if.waddr1 = 5'd0; bus_if.wdata1 = 32'hBEEF;
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd0;
        step();
        idle();
        step();

        // Bypass then array read.
        set_all_raddr(5'd5);
        bus_if.wen0 = 1'b1; bus_if.waddr0 = 5'd5; bus_if.wdata0 = 32'h1234;
        step();
        idle();
        step();

        // Collision: port 0 wins.
        set_all_raddr(5'd7);
        bus_if.wen0 = 1'b1; bus_if.waddr0 = 5'd7; bus_if.wdata0 = 32'h00AA;
        bus_if.wen1 = 1'b1; bus_if.waddr1 = 5'd7; bus_if.wdata1 = 32'h00BB;
        step();
        idle();
        step();
        chk("r7_after_collision", 64'(bus_if.rdata[DATA_W-1:0]), 64'h00AA);

        // Scoreboard lifetime.
        set_all_raddr(5'd9);
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd9;
        step();
        idle();
        for (int c = 1; c <= 3; c++) begin
            step();
        end
        chk("r9_busy_held", 64'(bus_if.rbusy[0]), 64'd1);
        bus_if.wen1 = 1'b1; bus_if.waddr1 = 5'd9; bus_if.wdata1 = 32'h0F0F;
        step();
        idle();
        step();
        chk("r9_busy_cleared", 64'(bus_if.rbusy[0]), 64'd0);

        // Reserve versus clear on the same register.
        set_all_raddr(5'd3);
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd3;
        step();
        bus_if.wen1 = 1'b1; bus_if.waddr1 = 5'd3; bus_if.wdata1 = 32'h0055;
        step();
        idle();
        step();
        chk("r3_still_busy", 64'(bus_if.rbusy[1]), 64'd1);

        // Mid-cycle reset with an outstanding reservation.
        bus_if.wen0 = 1'b1; bus_if.waddr0 = 5'd12; bus_if.wdata0 = 32'hCAFE_0012;
        step();
        idle();
        bus_if.rsv_en = 1'b1; bus_if.rsv_addr = 5'd12;
        step();
        idle();
        set_all_raddr(5'd12);
        #2 arst_n = 1'b0;
        model_clear();
        #1;
        check_ports();
        chk("r12_reset_busy", 64'(bus_if.rbusy[2]), 64'd0);
        #1 arst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        step();

        // Randomized traffic over a narrow address range to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            bus_if.wen0     = ($urandom_range(99, 0) < 40);
            bus_if.waddr0   = ADDR_W'($urandom_range(15, 0));
            bus_if.wdata0   = $urandom;
            bus_if.wen1     = ($urandom_range(99, 0) < 35);
            bus_if.waddr1   = ADDR_W'($urandom_range(15, 0));
            bus_if.wdata1   = $urandom;
            bus_if.rsv_en   = ($urandom_range(99, 0) < 30);
            bus_if.rsv_addr = ADDR_W'($urandom_range(15, 0));
            for (int k = 0; k < N_RD; k++)
                bus_if.raddr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(15, 0));
            if ($urandom_range(99, 0) < 20) begin
                bus_if.raddr[ADDR_W-1:0] = bus_if.waddr1;
            end
            step();
        end

        // Sweep every register through all ports after the random phase.
        idle();
        for (int r = 0; r < N_REG; r += N_RD) begin
            for (int k = 0; k < N_RD; k++) bus_if.raddr[k*ADDR_W +: ADDR_W] = ADDR_W'(r + k);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
